// File: rtl/pcie_tx_buf_if.sv
// Bundle of the DPK burst input, the TX streaming output and the status
// outputs of the download TX buffer. The slave modport is the buffer itself.
interface pcie_tx_buf_if #(
   parameter int P_AW = 9
);
   logic            DPK_TX_REQ;
   logic            DPK_TX_ACK;
   logic            DPK_TX_DVLD;
   logic [63:0]     DPK_TX_DATA;
   logic [1:0]      DPK_TX_MASK;
   logic            DPK_TX_SOP;
   logic            DPK_TX_EOP;
   logic            DPK_TX_END;

   logic            TX_ST_VALID;
   logic            TX_ST_READY;
   logic [63:0]     TX_ST_DATA;
   logic            TX_ST_SOP;
   logic            TX_ST_EOP;
   logic            TX_ST_EMPTY;

   logic [P_AW:0]   FIFO_CNT;
   logic            ERR_OVF;
   logic            ERR_PROTO;

   modport slave (
      input  DPK_TX_REQ, DPK_TX_DVLD, DPK_TX_DATA, DPK_TX_MASK,
             DPK_TX_SOP, DPK_TX_EOP, DPK_TX_END, TX_ST_READY,
      output DPK_TX_ACK, TX_ST_VALID, TX_ST_DATA, TX_ST_SOP, TX_ST_EOP,
             TX_ST_EMPTY, FIFO_CNT, ERR_OVF, ERR_PROTO
   );

   modport master (
      output DPK_TX_REQ, DPK_TX_DVLD, DPK_TX_DATA, DPK_TX_MASK,
             DPK_TX_SOP, DPK_TX_EOP, DPK_TX_END, TX_ST_READY,
      input  DPK_TX_ACK, TX_ST_VALID, TX_ST_DATA, TX_ST_SOP, TX_ST_EOP,
             TX_ST_EMPTY, FIFO_CNT, ERR_OVF, ERR_PROTO
   );
endinterface

// File: rtl/pcie_tx_buf.sv
// Download TX buffer: grants DPK bursts only when a maximum-size burst fits,
// stores qwords in a FIFO and replays them on a valid/ready stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// S_IDLE  | waiting for REQ with room for a full maximum-size burst
// S_GRANT | ACK asserted for this single cycle
// S_BURST | accepting qwords until DVLD & END
// S_GAP   | one dead cycle absorbing the upstream registered-REQ lag
module pcie_tx_buf #(
   parameter int P_AW        = 9,
   parameter int P_MAX_BURST = 66
) (
   input  logic          PCIE_CLK,
   input  logic          PCIE_RST,
   pcie_tx_buf_if.slave  bus
);
   localparam int DEPTH = 1 << P_AW;

   typedef enum logic [3:0] {
      S_IDLE  = 4'b0001,
      S_GRANT = 4'b0010,
      S_BURST = 4'b0100,
      S_GAP   = 4'b1000
   } state_t;

   state_t          state_q, state_d;
   logic [P_AW:0]   wr_ptr, rd_ptr, cnt_q;
   logic [P_AW+1:0] free_cnt;
   logic [66:0]     mem [DEPTH];
   logic            room, full, ram_empty, in_burst, wr_en, out_xfer, out_load;
   logic            out_vld, out_sop, out_eop, out_empty;
   logic [63:0]     out_data;
   logic            err_ovf_q, err_proto_q;

   // Free space counts the output register as occupied, so a granted burst
   // can never outrun the RAM.
   assign free_cnt  = (P_AW+2)'(DEPTH) - (P_AW+2)'(cnt_q);
   assign room      = free_cnt >= (P_AW+2)'(P_MAX_BURST);
   assign full      = (wr_ptr[P_AW] != rd_ptr[P_AW]) &&
                      (wr_ptr[P_AW-1:0] == rd_ptr[P_AW-1:0]);
   assign ram_empty = (wr_ptr == rd_ptr);
   assign in_burst  = (state_q == S_BURST);
   assign wr_en     = bus.DPK_TX_DVLD & in_burst & ~full;
   assign out_xfer  = out_vld & bus.TX_ST_READY;
   assign out_load  = (~out_vld | out_xfer) & ~ram_empty;

   // Grant FSM state register.
   always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
      if (PCIE_RST) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   // Grant FSM next-state decode.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:  if (bus.DPK_TX_REQ && room) state_d = S_GRANT;
         S_GRANT: state_d = S_BURST;
         S_BURST: if (bus.DPK_TX_DVLD && bus.DPK_TX_END) state_d = S_GAP;
         S_GAP:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FIFO storage; contents are don't-care after reset, so no reset here.
   always_ff @(posedge PCIE_CLK) begin
      if (wr_en)
         mem[wr_ptr[P_AW-1:0]] <= {bus.DPK_TX_DATA, bus.DPK_TX_SOP,
                                   bus.DPK_TX_EOP, (bus.DPK_TX_MASK == 2'b01)};
   end

   // Pointers and occupancy (RAM entries plus the output register).
   always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
      if (PCIE_RST) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (wr_en)    wr_ptr <= wr_ptr + 1'b1;
         if (out_load) rd_ptr <= rd_ptr + 1'b1;
         case ({wr_en, out_xfer})
            2'b10:   cnt_q <= cnt_q + 1'b1;
            2'b01:   cnt_q <= cnt_q - 1'b1;
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // First-word-fall-through output register; holds while stalled.
   always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
      if (PCIE_RST) begin
         out_vld   <= 1'b0;
         out_data  <= '0;
         out_sop   <= 1'b0;
         out_eop   <= 1'b0;
         out_empty <= 1'b0;
      end else if (out_load) begin
         out_vld <= 1'b1;
         {out_data, out_sop, out_eop, out_empty} <= mem[rd_ptr[P_AW-1:0]];
      end else if (out_xfer) begin
         out_vld <= 1'b0;
      end
   end

   // Sticky error flags, cleared only by reset.
   always_ff @(posedge PCIE_CLK or posedge PCIE_RST) begin
      if (PCIE_RST) begin
         err_ovf_q   <= 1'b0;
         err_proto_q <= 1'b0;
      end else begin
         if (bus.DPK_TX_DVLD && !in_burst)        err_proto_q <= 1'b1;
         if (bus.DPK_TX_DVLD && in_burst && full) err_ovf_q   <= 1'b1;
      end
   end

   assign bus.DPK_TX_ACK  = (state_q == S_GRANT);
   assign bus.TX_ST_VALID = out_vld;
   assign bus.TX_ST_DATA  = out_data;
   assign bus.TX_ST_SOP   = out_sop;
   assign bus.TX_ST_EOP   = out_eop;
   assign bus.TX_ST_EMPTY = out_empty;
   assign bus.FIFO_CNT    = cnt_q;
   assign bus.ERR_OVF     = err_ovf_q;
   assign bus.ERR_PROTO   = err_proto_q;
endmodule

// File: tb/tb_pcie_tx_buf.sv
// Directed bench for pcie_tx_buf with a scoreboard on the output stream.
module tb_pcie_tx_buf;
   localparam int P_AW = 9;

   logic PCIE_CLK = 1'b0;
   logic PCIE_RST = 1'b1;

   pcie_tx_buf_if #(.P_AW(P_AW)) bus ();

   pcie_tx_buf #(.P_AW(P_AW), .P_MAX_BURST(66)) dut (
      .PCIE_CLK (PCIE_CLK),
      .PCIE_RST (PCIE_RST),
      .bus      (bus.slave)
   );

   always #5 PCIE_CLK = ~PCIE_CLK;

   int          n_chk = 0;
   int          n_err = 0;
   logic [66:0] sb [$];
   bit          rnd_on = 1'b0;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change 1 time unit after the rising edge.
   task automatic tick();
      @(posedge PCIE_CLK);
      #1;
      if (rnd_on) bus.TX_ST_READY = 1'($urandom_range(0, 1));
   endtask

   task automatic set_qw(input logic [63:0] d, input logic sop, input logic eop,
                         input logic [1:0] m, input logic last);
      bus.DPK_TX_DVLD = 1'b1;
      bus.DPK_TX_DATA = d;
      bus.DPK_TX_SOP  = sop;
      bus.DPK_TX_EOP  = eop;
      bus.DPK_TX_MASK = m;
      bus.DPK_TX_END  = last;
      sb.push_back({d, sop, eop, (m == 2'b01)});
   endtask

   task automatic clr_qw();
      bus.DPK_TX_DVLD = 1'b0;
      bus.DPK_TX_SOP  = 1'b0;
      bus.DPK_TX_EOP  = 1'b0;
      bus.DPK_TX_END  = 1'b0;
      bus.DPK_TX_MASK = 2'b11;
   endtask

   // Raises REQ and waits for ACK; returns the REQ-to-ACK cycle count.
   task automatic wait_grant(input int bound, output bit ok, output int lat);
      ok  = 1'b0;
      lat = 0;
      bus.DPK_TX_REQ = 1'b1;
      for (int c = 1; c <= bound; c++) begin
         tick();
         if (bus.DPK_TX_ACK) begin
            ok  = 1'b1;
            lat = c;
            break;
         end
      end
      bus.DPK_TX_REQ = 1'b0;
   endtask

   // Data phase: first qword is driven one cycle after ACK was seen.
   task automatic send_data(input int n, input logic [1:0] last_mask, input logic [31:0] tag);
      tick();
      for (int i = 0; i < n; i++) begin
         set_qw({tag, 32'(i)}, (i == 0), (i == n - 1),
                (i == n - 1) ? last_mask : 2'b11, (i == n - 1));
         tick();
      end
      clr_qw();
   endtask

   task automatic send_burst(input int n, input logic [1:0] last_mask,
                             input logic [31:0] tag, input int bound);
      bit ok;
      int lat;
      wait_grant(bound, ok, lat);
      chk("grant", 128'(ok), 128'(1));
      if (ok) send_data(n, last_mask, tag);
   endtask

   task automatic drain(input int bound);
      bit done;
      done = 1'b0;
      for (int c = 0; c < bound; c++) begin
         if (sb.size() == 0 && !bus.TX_ST_VALID) begin
            done = 1'b1;
            break;
         end
         tick();
      end
      chk("drain_done", 128'(done), 128'(1));
   endtask

   // Scoreboard: every output transfer must match the next written qword.
   always @(negedge PCIE_CLK) begin
      if (!PCIE_RST && bus.TX_ST_VALID && bus.TX_ST_READY) begin
         if (sb.size() == 0) begin
            chk("stream_extra", 128'(1), 128'(0));
         end else begin
            logic [66:0] e;
            e = sb.pop_front();
            chk("stream", 128'({bus.TX_ST_DATA, bus.TX_ST_SOP, bus.TX_ST_EOP, bus.TX_ST_EMPTY}),
                128'(e));
         end
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit ok;
      bit saw;
      int lat;

      bus.DPK_TX_REQ  = 1'b0;
      bus.DPK_TX_DATA = '0;
      bus.TX_ST_READY = 1'b0;
      clr_qw();

      // Reset state.
      repeat (3) tick();
      chk("rst_ack",   128'(bus.DPK_TX_ACK),  128'(0));
      chk("rst_valid", 128'(bus.TX_ST_VALID), 128'(0));
      chk("rst_data",  128'({bus.TX_ST_DATA, bus.TX_ST_SOP, bus.TX_ST_EOP, bus.TX_ST_EMPTY}), 128'(0));
      chk("rst_cnt",   128'(bus.FIFO_CNT),    128'(0));
      chk("rst_err",   128'({bus.ERR_OVF, bus.ERR_PROTO}), 128'(0));
      PCIE_RST = 1'b0;
      tick();

      // Single 3-qword burst, READY=1, explicit timing.
      bus.TX_ST_READY = 1'b1;
      wait_grant(10, ok, lat);
      chk("t1_grant", 128'(ok), 128'(1));
      chk("t1_ack_lat", 128'(lat), 128'(1));
      tick();
      set_qw(64'h1111_0000_0000_00D0, 1'b1, 1'b0, 2'b11, 1'b0);
      tick();
      set_qw(64'h1111_0000_0000_00D1, 1'b0, 1'b0, 2'b11, 1'b0);
      tick();
      set_qw(64'h1111_0000_0000_00D2, 1'b0, 1'b1, 2'b11, 1'b1);
      chk("t1_d0", 128'({bus.TX_ST_VALID, bus.TX_ST_DATA, bus.TX_ST_SOP}),
          128'({1'b1, 64'h1111_0000_0000_00D0, 1'b1}));
      tick();
      clr_qw();
      chk("t1_d1", 128'({bus.TX_ST_VALID, bus.TX_ST_DATA}), 128'({1'b1, 64'h1111_0000_0000_00D1}));
      tick();
      chk("t1_d2", 128'({bus.TX_ST_VALID, bus.TX_ST_DATA, bus.TX_ST_EOP, bus.TX_ST_EMPTY}),
          128'({1'b1, 64'h1111_0000_0000_00D2, 1'b1, 1'b0}));
      tick();
      chk("t1_valid_end", 128'(bus.TX_ST_VALID), 128'(0));
      chk("t1_cnt_end",   128'(bus.FIFO_CNT),    128'(0));

      // Lower-dword-only final qword.
      send_burst(2, 2'b01, 32'h2222, 20);
      send_burst(1, 2'b01, 32'h2223, 20);
      drain(50);

      // Fill with READY=0: grant threshold at 446/447.
      bus.TX_ST_READY = 1'b0;
      tick();
      send_burst(66, 2'b11, 32'h3000, 20);
      chk("fill_cnt66", 128'(bus.FIFO_CNT), 128'(66));
      chk("fill_noack", 128'(bus.DPK_TX_ACK), 128'(0));
      for (int b = 1; b < 6; b++) send_burst(66, 2'b11, 32'h3000 + 32'(b), 20);
      chk("fill_cnt396", 128'(bus.FIFO_CNT), 128'(396));
      send_burst(51, 2'b11, 32'h3006, 20);
      chk("fill_cnt447", 128'(bus.FIFO_CNT), 128'(447));
      bus.DPK_TX_REQ = 1'b1;
      saw = 1'b0;
      repeat (6) begin
         tick();
         saw |= bus.DPK_TX_ACK;
      end
      chk("fill_withheld", 128'(saw), 128'(0));
      bus.TX_ST_READY = 1'b1;
      tick();
      bus.TX_ST_READY = 1'b0;
      chk("fill_cnt446", 128'(bus.FIFO_CNT), 128'(446));
      wait_grant(5, ok, lat);
      chk("fill_grant446", 128'(ok), 128'(1));
      if (ok) send_data(1, 2'b11, 32'h3007);
      chk("fill_cnt447b", 128'(bus.FIFO_CNT), 128'(447));
      bus.TX_ST_READY = 1'b1;
      drain(1200);
      chk("fill_cnt_end", 128'(bus.FIFO_CNT), 128'(0));

      // Random READY through 10 bursts of random length.
      rnd_on = 1'b1;
      for (int b = 0; b < 10; b++)
         send_burst($urandom_range(1, 66), ($urandom_range(0, 1) != 0) ? 2'b01 : 2'b11,
                    32'h4000 + 32'(b), 3000);
      drain(3000);
      rnd_on = 1'b0;
      bus.TX_ST_READY = 1'b1;
      tick();
      chk("rnd_sb_left", 128'(sb.size()), 128'(0));
      chk("rnd_ovf",     128'(bus.ERR_OVF), 128'(0));

      // DVLD outside a granted burst.
      chk("proto_pre", 128'(bus.ERR_PROTO), 128'(0));
      bus.DPK_TX_DVLD = 1'b1;
      bus.DPK_TX_DATA = 64'hDEAD_BEEF_0000_0001;
      tick();
      clr_qw();
      chk("proto_set", 128'(bus.ERR_PROTO), 128'(1));
      chk("proto_cnt", 128'(bus.FIFO_CNT),  128'(0));
      repeat (5) tick();
      chk("proto_sticky", 128'({bus.ERR_PROTO, bus.TX_ST_VALID}), 128'({1'b1, 1'b0}));

      // Reset mid-burst with 20 qwords buffered.
      bus.TX_ST_READY = 1'b0;
      wait_grant(10, ok, lat);
      chk("mrst_grant", 128'(ok), 128'(1));
      tick();
      for (int i = 0; i < 20; i++) begin
         set_qw({32'h5000, 32'(i)}, (i == 0), 1'b0, 2'b11, 1'b0);
         tick();
      end
      clr_qw();
      chk("mrst_cnt20", 128'({bus.TX_ST_VALID, bus.FIFO_CNT}), 128'({1'b1, 10'd20}));
      PCIE_RST = 1'b1;
      #1;
      chk("mrst_valid", 128'(bus.TX_ST_VALID), 128'(0));
      chk("mrst_cnt",   128'(bus.FIFO_CNT),    128'(0));
      chk("mrst_err",   128'(bus.ERR_PROTO),   128'(0));
      sb.delete();
      tick();
      PCIE_RST = 1'b0;
      tick();
      bus.TX_ST_READY = 1'b1;
      send_burst(4, 2'b11, 32'h6000, 20);
      drain(50);
      chk("post_cnt", 128'(bus.FIFO_CNT), 128'(0));
      chk("post_err", 128'({bus.ERR_OVF, bus.ERR_PROTO}), 128'(0));

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule

// File: doc/pcie_tx_buf.md
# pcie_tx_buf

Download TX buffer stage. It sits directly downstream of the download arbiter (PCIE_DN_ARBIT) and consumes its merged DPK_TX_* burst stream. It grants bursts only when a full maximum-size burst fits, stores the qwords in an internal FIFO, and replays them on a valid/ready streaming TX port toward the PCIe hard-IP adapter. Its job is to decouple the non-stallable DPK burst from hard-IP backpressure.

## Interface
- P_AW, 9: FIFO address width; depth = 2^P_AW qwords (512).
- P_MAX_BURST, 66: maximum qwords in one DPK burst (REQ..END); this is the grant threshold.
- PCIE_CLK  in  1  clock; everything is synchronous to its rising edge.
- PCIE_RST  in  1  reset, asynchronous, active-high.
- DPK_TX_REQ  in  1  a burst is pending (level).
- DPK_TX_ACK  out  1  single-cycle grant pulse.
- DPK_TX_DVLD  in  1  qword valid.
- DPK_TX_DATA  in  64  qword; the lower dword is the first dword.
- DPK_TX_MASK  in  2  dword enables; 2'b11 = full qword, 2'b01 = lower dword only; 2'b01 is legal only with EOP.
- DPK_TX_SOP / DPK_TX_EOP  in  1 each  TLP start and end.
- DPK_TX_END  in  1  last qword of the burst; always coincides with EOP.
- TX_ST_VALID  out  1  output qword valid.
- TX_ST_READY  in  1  sink ready; transfer = VALID & READY.
- TX_ST_DATA  out  64  output qword.
- TX_ST_SOP / TX_ST_EOP  out  1 each  TLP markers.
- TX_ST_EMPTY  out  1  1 = upper dword unused; meaningful only with EOP.
- FIFO_CNT  out  P_AW+1  occupancy, including the output register.
- ERR_OVF  out  1  sticky: a qword was written while full.
- ERR_PROTO  out  1  sticky: DVLD seen outside a granted burst.

## Operation
- Grant FSM has four one-hot states: IDLE, GRANT, BURST, GAP.
- IDLE -> GRANT when DPK_TX_REQ=1 and (2^P_AW − FIFO_CNT) ≥ P_MAX_BURST. Otherwise stay in IDLE.
- GRANT: DPK_TX_ACK=1 for exactly this cycle, then -> BURST unconditionally.
- BURST: each DVLD=1 cycle writes {DATA, SOP, EOP, EMPTY = (MASK==2'b01)} into the FIFO. The burst source cannot be stalled.
- BURST -> GAP on DVLD & END.
- GAP lasts one cycle, ignores REQ, then -> IDLE. This covers the one-cycle lag of the upstream registered REQ.
- DVLD in IDLE, GRANT or GAP: the qword is discarded and ERR_PROTO is set.
- DVLD while FIFO is full (should not happen given the grant rule): the qword is discarded and ERR_OVF is set.
- FIFO storage: dual-port RAM, 67 bits wide. Read side is a first-word-fall-through output register feeding TX_ST_*.
- The output register reloads when it is empty, or when VALID & READY and the RAM is non-empty.
- FIFO_CNT increments on an accepted write and decrements on an output transfer. When both happen in the same cycle it is unchanged.
- Pointers are P_AW+1 bits and wrap modulo 2^(P_AW+1). Full = MSBs differ and the rest are equal.
- The block only buffers; it never reorders, modifies or drops a qword within a granted burst.

## Timing
- Reset values: DPK_TX_ACK=0, TX_ST_VALID=0, TX_ST_DATA=0, SOP/EOP/EMPTY=0, FIFO_CNT=0, ERR_*=0, FSM=IDLE, pointers=0.
- Reset mid-burst: FIFO contents are lost and the outputs return to their reset values immediately (asynchronous). Upstream is reset by the same PCIE_RST.
- REQ sampled high at edge k (with room) -> GRANT state after k -> ACK high during cycle k..k+1.
- Minimum REQ-to-ACK latency is 1 cycle; ACK is registered.
- Write/read latency: a qword written at edge k is on TX_ST_* with VALID=1 after edge k+1, provided the FIFO was empty. Otherwise it appears in order.
- Output throughput: one qword per cycle while READY=1.
- TX_ST_* holds stable while VALID=1 and READY=0.
- Back-to-back bursts: END at edge e -> GAP after e -> IDLE after e+1. Earliest next ACK is cycle e+2..e+3.
- Write to an empty FIFO and READY=1 in the same cycle: the qword appears next cycle; no bypass.

## Test plan
- Single burst (3 qwords D0..D2, SOP on D0, EOP+END on D2, MASK 2'b11) on an empty FIFO with READY=1:
  - ACK is 1 cycle after REQ.
  - TX_ST_DATA shows D0, D1, D2 on consecutive cycles, 2 cycles after each DVLD.
  - EMPTY=0 and FIFO_CNT ends at 0.
- Final qword with MASK=2'b01 plus EOP -> TX_ST_EMPTY=1 only on that EOP beat.
- READY=0 while 66 qwords are written -> FIFO_CNT=66 and no ACK.
  - With depth 512, a second REQ is granted.
  - Fill to 447, then a new REQ is withheld until one transfer brings FIFO_CNT to 446.
- READY toggled 1/0 at random through 10 bursts of 1–66 qwords -> output stream equals the input stream bit-exactly, and ERR_OVF=0.
- DVLD pulsed in IDLE -> ERR_PROTO=1, FIFO_CNT unchanged, and the flag stays set until reset.
- PCIE_RST asserted mid-burst with FIFO_CNT=20 -> same cycle VALID=0 and FIFO_CNT=0. After release, a new burst passes correctly.
